lsu_aligner: RTL and testbench
==============================

Name: lsu_aligner

Overview:
- Parametrised load/store unit for the multicycle core; successor to the single-cycle DPI memory stage.
- Accepts one load/store per transaction over a valid/ready request channel. Issues an aligned access with byte strobes to a handshaked memory port and returns sign/zero-extended load data over a valid/ready response channel.
- Adds over the previous stage: XLEN generalisation (32/64), store lane shifting and strobe generation, misalignment and illegal-op detection, and a bus timeout counter.

Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- AW, 32, address width.
- TIMEOUT, 255, maximum cycles spent in ISSUE+WAIT before the access is aborted with a timeout error; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_wen  in  1  1 = store, 0 = load.
- req_op  in  3  funct3 encoding: 0 B, 1 H, 2 W, 3 D, 4 BU, 5 HU, 6 WU.
- req_addr  in  AW  byte address.
- req_wdata  in  XLEN  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  response consumed.
- resp_rdata  out  XLEN  extended load data; 0 for stores and for errors.
- resp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal op.
- mem_valid  out  1  memory request.
- mem_ready  in  1  memory accepted the request.
- mem_wen  out  1  write enable.
- mem_addr  out  AW  req_addr with low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  XLEN/8  byte strobes; all-zero for loads.
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle.
- mem_rdata  in  XLEN  raw aligned read word.

Behaviour:
- Reset (rst high at an edge):
  - state is IDLE and the counter is 0.
  - Output values: req_ready=1, resp_valid=0, mem_valid=0, resp_rdata=0, resp_err=0, mem_wen=0, mem_wstrb=0.
  - Reset mid-transaction abandons the access. mem_valid is low the cycle after reset; a late mem_ack arriving in IDLE is ignored.
- Lane decode:
  - off = req_addr[log2(XLEN/8)-1:0]; size = 1/2/4/8 bytes from op[1:0].
- Classification, checked at acceptance:
  - illegal (err 3) takes priority over misaligned.
  - Illegal ops: op 7; op 3 when XLEN=32; op 6 when XLEN=32; store with op[2]=1.
  - Misaligned (err 1): off not a multiple of size.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE:
    - req_ready=1. On req_valid, latch wen, op, addr and wdata.
    - If illegal or misaligned, go to RESP with the error code; no memory access is made.
    - Otherwise go to ISSUE with counter=0.
  - ISSUE:
    - mem_valid=1 with mem_addr, mem_wen, mem_wdata and mem_wstrb held stable until mem_ready.
    - On mem_ready go to WAIT.
  - WAIT:
    - mem_valid=0. On mem_ack, latch the extracted data and go to RESP with err 0.
    - mem_ack is honoured only in WAIT; the earliest ack is the cycle after mem_ready.
  - Counter:
    - increments every cycle in ISSUE and WAIT.
    - If it reaches TIMEOUT before the exit condition: go to RESP with err 2 and rdata 0, and drop mem_valid.
    - mem_ready/mem_ack arriving in the same cycle as timeout wins over the timeout.
  - RESP:
    - resp_valid=1, with rdata and err stable until resp_ready; then go to IDLE.
    - No new request is accepted in the same cycle.
- Stores:
  - mem_wdata = req_wdata << (8*off).
  - mem_wstrb = ((1<<size)-1) << off.
  - resp_rdata = 0.
- Loads:
  - sh = mem_rdata >> (8*off); take the low size bytes.
  - Sign-extend for op 0/1/2; zero-extend for op 4/5/6.
  - op 2 and op 3 when XLEN=32 both return the full word.
- Latency (ready memory): acceptance in cycle 0, mem_valid in cycle 1, mem_ack in cycle 2, resp_valid in cycle 3.
- Error responses appear in cycle 1 after acceptance.

Test Plan:
- XLEN=32, load op 0 at addr 0x1003, mem_rdata=0x80FFFFFF → mem_addr=0x1000, mem_wstrb=0, resp_rdata=0xFFFFFF80, err 0, resp_valid in cycle 3.
- XLEN=32, load op 5 at 0x2002, mem_rdata=0xBEEF1234 → resp_rdata=0x0000BEEF.
- XLEN=32, store op 1 at 0x2002, wdata=0xAAAA5566 → mem_wdata=0x55660000, mem_wstrb=4'b1100, mem_wen=1, resp_rdata=0.
- XLEN=32, load op 2 at 0x3001 → resp_err=1 in cycle 1, mem_valid never asserted. Op 3 at 0x3000 → resp_err=3.
- TIMEOUT=4, mem_ready=1 and mem_ack never asserted → resp_err=2 and rdata 0 after 4 counted cycles. A mem_ack arriving later in IDLE is ignored.
- XLEN=64, load op 6 at 0x4004, mem_rdata=0x8000_0001_xxxx_xxxx → resp_rdata=0x0000_0000_8000_0001. rst pulsed in WAIT → mem_valid=0, req_ready=1 next cycle, resp_valid stays 0.

Source files
------------

// File: rtl/lsu_aligner.sv
// lsu_aligner: load/store unit that turns one byte-addressed request into an
// aligned, byte-strobed memory access and returns extended load data.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : valid/ready request channel (wen, op, addr, wdata)
//   resp_*              : valid/ready response channel (rdata, err)
//   mem_valid/mem_ready : memory request handshake (addr, wen, wdata, wstrb)
//   mem_ack/mem_rdata   : memory completion, read word valid with the ack
module lsu_aligner #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_op,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int unsigned NB = XLEN / 8;
  localparam int unsigned OW = $clog2(NB);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ERR_OK  = 2'd0;
  localparam logic [1:0] ERR_MIS = 2'd1;
  localparam logic [1:0] ERR_TO  = 2'd2;
  localparam logic [1:0] ERR_ILL = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wen_q, wen_d;
  logic [2:0]      op_q, op_d;
  logic [OW-1:0]   off_q, off_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NB-1:0]   strb_q, strb_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;

  // Request decode: lane offset, access size, classification, store lanes.
  logic [OW-1:0]   req_off;
  logic [3:0]      req_size;
  logic            req_illegal;
  logic            req_misal;
  logic [NB-1:0]   req_strb;
  logic [XLEN-1:0] req_wdata_sh;

  always_comb begin
    req_off = req_addr[OW-1:0];
    case (req_op[1:0])
      2'd0:    req_size = 4'd1;
      2'd1:    req_size = 4'd2;
      2'd2:    req_size = 4'd4;
      default: req_size = 4'd8;
    endcase
    req_illegal = (req_op == 3'd7) || (req_wen && req_op[2]) ||
                  ((XLEN == 32) && ((req_op == 3'd3) || (req_op == 3'd6)));
    req_misal    = (req_off & OW'(req_size - 4'd1)) != '0;
    req_strb     = NB'((16'd1 << req_size) - 16'd1) << req_off;
    req_wdata_sh = req_wdata << {req_off, 3'b000};
  end

  // Load extraction: shift the addressed lane down, keep size bytes, and
  // fill the upper bytes with the sign bit for signed ops.
  logic [XLEN-1:0] ld_sh;
  logic [XLEN-1:0] ld_keep;
  logic            ld_sgn;
  logic [XLEN-1:0] ld_ext;

  always_comb begin
    ld_sh = mem_rdata >> {off_q, 3'b000};
    case (op_q[1:0])
      2'd0: begin
        ld_keep = XLEN'(8'hFF);
        ld_sgn  = ld_sh[7];
      end
      2'd1: begin
        ld_keep = XLEN'(16'hFFFF);
        ld_sgn  = ld_sh[15];
      end
      2'd2: begin
        ld_keep = XLEN'(32'hFFFF_FFFF);
        ld_sgn  = ld_sh[31];
      end
      default: begin
        ld_keep = '1;
        ld_sgn  = 1'b0;
      end
    endcase
    ld_ext = (ld_sh & ld_keep) | ({XLEN{ld_sgn & ~op_q[2]}} & ~ld_keep);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      op_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      op_q    <= op_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The counter saturates at TIMEOUT so a ready taken on
  // the last ISSUE cycle still leaves WAIT exactly one cycle to see the ack.
  logic [CW-1:0] cnt_inc;
  logic          to_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    op_d    = op_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    to_hit  = (cnt_inc == CW'(TIMEOUT));
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          op_d    = req_op;
          off_d   = req_off;
          addr_d  = {req_addr[AW-1:OW], OW'(0)};
          wdata_d = req_wdata_sh;
          strb_d  = req_wen ? req_strb : '0;
          rdata_d = '0;
          if (req_illegal) begin
            state_d = S_RESP;
            err_d   = ERR_ILL;
          end else if (req_misal) begin
            state_d = S_RESP;
            err_d   = ERR_MIS;
          end else begin
            state_d = S_ISSUE;
            cnt_d   = '0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_inc;
        if (mem_ready) begin
          state_d = S_WAIT;
        end else if (to_hit) begin
          state_d = S_RESP;
          err_d   = ERR_TO;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (mem_ack) begin
          state_d = S_RESP;
          err_d   = ERR_OK;
          rdata_d = wen_q ? '0 : ld_ext;
        end else if (to_hit) begin
          state_d = S_RESP;
          err_d   = ERR_TO;
          rdata_d = '0;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = ERR_OK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register and latched payload.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    mem_valid  = (state_q == S_ISSUE);
    resp_valid = (state_q == S_RESP);
    mem_wen    = (state_q == S_ISSUE) && wen_q;
    mem_wstrb  = (state_q == S_ISSUE) ? strb_q : '0;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_lsu_aligner.sv
// Bench for lsu_aligner: one XLEN=32 and one XLEN=64 instance share the
// stimulus, selected by sel. A byte-level model predicts each transaction;
// a negedge compare process checks the selected instance every cycle.
module tb_lsu_aligner;

  localparam int unsigned T32 = 4;
  localparam int unsigned T64 = 6;

  logic        clk = 1'b0;
  logic        rst, sel;
  logic        req_valid, req_wen, resp_ready, mem_ready, mem_ack;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;

  logic        a_req_ready, a_resp_valid, a_mem_valid, a_mem_wen;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [1:0]  a_resp_err;
  logic [3:0]  a_mem_wstrb;

  logic        b_req_ready, b_resp_valid, b_mem_valid, b_mem_wen;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [1:0]  b_resp_err;
  logic [7:0]  b_mem_wstrb;

  logic        o_req_ready, o_resp_valid, o_mem_valid, o_mem_wen;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [1:0]  o_resp_err;
  logic [7:0]  o_mem_wstrb;

  logic        chk_en, e_req_ready, e_mem_valid, e_resp_valid, e_mem_wen, e_zero;
  logic [31:0] e_addr;
  logic [63:0] e_wd, e_rdata;
  logic [7:0]  e_strb;
  logic [1:0]  e_err;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  lsu_aligner #(.XLEN(32), .AW(32), .TIMEOUT(T32)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_wen(req_wen),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready & ~sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready & ~sel), .mem_wen(a_mem_wen),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .mem_ack(mem_ack & ~sel), .mem_rdata(mem_rdata[31:0])
  );

  lsu_aligner #(.XLEN(64), .AW(32), .TIMEOUT(T64)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_wen(req_wen),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready & sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready & sel), .mem_wen(b_mem_wen),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wstrb(b_mem_wstrb),
    .mem_ack(mem_ack & sel), .mem_rdata(mem_rdata)
  );

  always_comb begin
    o_req_ready  = sel ? b_req_ready  : a_req_ready;
    o_resp_valid = sel ? b_resp_valid : a_resp_valid;
    o_mem_valid  = sel ? b_mem_valid  : a_mem_valid;
    o_mem_wen    = sel ? b_mem_wen    : a_mem_wen;
    o_resp_rdata = sel ? b_resp_rdata : {32'b0, a_resp_rdata};
    o_mem_wdata  = sel ? b_mem_wdata  : {32'b0, a_mem_wdata};
    o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
    o_resp_err   = sel ? b_resp_err   : a_resp_err;
    o_mem_wstrb  = sel ? b_mem_wstrb  : {4'b0, a_mem_wstrb};
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t sel=%0b)", name, got, exp, $time, sel);
    else
      n_pass++;
  endtask

  // Byte-level reference: what the unit must do for one request given the
  // memory's ready delay rd and ack delay ad (cycles of waiting in each).
  function automatic void model(input bit s64, input logic [2:0] op, input bit wen,
                                input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [63:0] word, input int rd, input int ad,
                                output logic [1:0] err, output logic [63:0] rdata,
                                output logic [31:0] maddr, output logic [63:0] wd,
                                output logic [7:0] strb, output int rc);
    int nb, off, size, tmo, iss, allow;
    nb    = s64 ? 8 : 4;
    tmo   = s64 ? int'(T64) : int'(T32);
    off   = int'(addr[2:0]) % nb;
    size  = 1 << op[1:0];
    maddr = addr - 32'(off);
    wd    = '0;
    strb  = '0;
    rdata = '0;
    for (int k = 0; k < nb; k++) begin
      if (k >= off) wd[8*k +: 8] = wdata[8*(k-off) +: 8];
      if (wen && k >= off && k < off + size) strb[k] = 1'b1;
    end
    iss   = rd + 1;
    allow = (tmo - iss > 1) ? tmo - iss : 1;
    if (op == 3'd7 || (wen && op >= 3'd4) || (!s64 && (op == 3'd3 || op == 3'd6))) begin
      err = 2'd3; rc = 1;
    end else if (off % size != 0) begin
      err = 2'd1; rc = 1;
    end else if (iss > tmo) begin
      err = 2'd2; rc = tmo + 1;
    end else if (ad + 1 > allow) begin
      err = 2'd2; rc = iss + allow + 1;
    end else begin
      err = 2'd0; rc = rd + ad + 3;
      if (!wen) begin
        for (int i = 0; i < size; i++) rdata[8*i +: 8] = word[8*(off+i) +: 8];
        if (op < 3'd4 && word[8*(off+size)-1])
          for (int i = size; i < nb; i++) rdata[8*i +: 8] = 8'hFF;
      end
    end
  endfunction

  // Compare process: the selected instance against the current expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 64'(o_req_ready), 64'(e_req_ready));
      chk("mem_valid", 64'(o_mem_valid), 64'(e_mem_valid));
      chk("resp_valid", 64'(o_resp_valid), 64'(e_resp_valid));
      if (e_mem_valid) begin
        chk("mem_addr", 64'(o_mem_addr), 64'(e_addr));
        chk("mem_wen", 64'(o_mem_wen), 64'(e_mem_wen));
        chk("mem_wstrb", 64'(o_mem_wstrb), 64'(e_strb));
        if (e_mem_wen) chk("mem_wdata", o_mem_wdata, e_wd);
      end
      if (e_resp_valid) begin
        chk("resp_rdata", o_resp_rdata, e_rdata);
        chk("resp_err", 64'(o_resp_err), 64'(e_err));
      end
      if (e_zero) begin
        chk("rst_mem_wen", 64'(o_mem_wen), 64'd0);
        chk("rst_mem_wstrb", 64'(o_mem_wstrb), 64'd0);
        chk("rst_resp_rdata", o_resp_rdata, 64'd0);
        chk("rst_resp_err", 64'(o_resp_err), 64'd0);
      end
    end
  end

  task automatic idle_inputs();
    req_valid  = 1'b0;
    mem_ready  = 1'b0;
    mem_ack    = 1'b0;
    resp_ready = 1'b0;
    e_req_ready  = 1'b1;
    e_mem_valid  = 1'b0;
    e_resp_valid = 1'b0;
  endtask

  // One transaction, cycle c = 0 is the acceptance cycle.
  task automatic run(input bit s64, input logic [2:0] op, input bit wen,
                     input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [63:0] word, input int rd, input int ad, input int hold);
    logic [1:0]  m_err;
    logic [63:0] m_rdata, m_wd;
    logic [31:0] m_addr;
    logic [7:0]  m_strb;
    int rc, ack_c, last, tmo;
    bit early;
    model(s64, op, wen, addr, wdata, word, rd, ad, m_err, m_rdata, m_addr, m_wd, m_strb, rc);
    early = (m_err == 2'd1) || (m_err == 2'd3);
    tmo   = s64 ? int'(T64) : int'(T32);
    ack_c = rd + 2 + ad;
    last  = rc + hold + 2;
    if (ack_c + 1 > last) last = ack_c + 1;
    sel = s64; req_wen = wen; req_op = op; req_addr = addr; req_wdata = wdata;
    e_zero = 1'b0; e_mem_wen = wen; e_addr = m_addr; e_wd = m_wd; e_strb = m_strb;
    e_rdata = m_rdata; e_err = m_err;
    for (int c = 0; c <= last; c++) begin
      req_valid    = (c == 0);
      mem_ready    = !early && (c == rd + 1);
      mem_ack      = !early && (c == ack_c);
      mem_rdata    = (c == ack_c) ? word : {$urandom, $urandom};
      resp_ready   = (c == rc + hold);
      e_req_ready  = (c == 0) || (c > rc + hold);
      e_mem_valid  = !early && c >= 1 && c <= rd + 1 && c <= tmo;
      e_resp_valid = (c >= rc) && (c <= rc + hold);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // Reset pulsed while an XLEN=64 load sits in WAIT, then a stray ack in IDLE.
  task automatic reset_in_wait();
    logic [1:0]  m_err;
    logic [63:0] m_rdata, m_wd;
    logic [31:0] m_addr;
    logic [7:0]  m_strb;
    int rc;
    model(1'b1, 3'd6, 1'b0, 32'h4004, 64'd0, 64'h8000_0001_1234_5678, 0, 0,
          m_err, m_rdata, m_addr, m_wd, m_strb, rc);
    sel = 1'b1; req_wen = 1'b0; req_op = 3'd6; req_addr = 32'h4004; req_wdata = '0;
    e_zero = 1'b0; e_mem_wen = 1'b0; e_addr = m_addr; e_strb = m_strb;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b1; e_req_ready = 1'b0; e_mem_valid = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0; rst = 1'b1; e_mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 64'h8000_0001_1234_5678;
    e_req_ready = 1'b1; e_zero = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0]  p_err;
    logic [63:0] p_rdata, p_wd;
    logic [31:0] p_addr;
    logic [7:0]  p_strb;
    int p_rc;

    chk_en = 1'b0; sel = 1'b0; rst = 1'b1;
    req_wen = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; mem_rdata = '0;
    e_mem_wen = 1'b0; e_addr = '0; e_wd = '0; e_strb = '0; e_rdata = '0; e_err = '0;
    idle_inputs();
    @(posedge clk); #1;
    e_zero = 1'b1; chk_en = 1'b1;
    @(posedge clk); #1;
    sel = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; sel = 1'b0;
    @(posedge clk); #1;

    // Pin the model to hand-computed values.
    model(1'b0, 3'd0, 1'b0, 32'h1003, 64'd0, 64'h80FF_FFFF, 0, 0, p_err, p_rdata, p_addr, p_wd, p_strb, p_rc);
    chk("pin_lb_rdata", p_rdata, 64'hFFFF_FF80);
    chk("pin_lb_addr", 64'(p_addr), 64'h1000);
    chk("pin_lb_cycle", 64'(p_rc), 64'd3);
    model(1'b0, 3'd5, 1'b0, 32'h2002, 64'd0, 64'hBEEF_1234, 0, 0, p_err, p_rdata, p_addr, p_wd, p_strb, p_rc);
    chk("pin_lhu_rdata", p_rdata, 64'h0000_BEEF);
    model(1'b0, 3'd1, 1'b1, 32'h2002, 64'hAAAA_5566, 64'd0, 0, 0, p_err, p_rdata, p_addr, p_wd, p_strb, p_rc);
    chk("pin_sh_wdata", p_wd, 64'h5566_0000);
    chk("pin_sh_wstrb", 64'(p_strb), 64'hC);
    model(1'b0, 3'd2, 1'b0, 32'h3001, 64'd0, 64'd0, 0, 0, p_err, p_rdata, p_addr, p_wd, p_strb, p_rc);
    chk("pin_mis_err", 64'(p_err), 64'd1);
    model(1'b0, 3'd3, 1'b0, 32'h3000, 64'd0, 64'd0, 0, 0, p_err, p_rdata, p_addr, p_wd, p_strb, p_rc);
    chk("pin_ill_err", 64'(p_err), 64'd3);
    model(1'b0, 3'd2, 1'b0, 32'h1000, 64'd0, 64'd0, 0, 9, p_err, p_rdata, p_addr, p_wd, p_strb, p_rc);
    chk("pin_to_err", 64'(p_err), 64'd2);
    chk("pin_to_cycle", 64'(p_rc), 64'd5);
    model(1'b1, 3'd6, 1'b0, 32'h4004, 64'd0, 64'h8000_0001_1234_5678, 0, 0, p_err, p_rdata, p_addr, p_wd, p_strb, p_rc);
    chk("pin_lwu64_rdata", p_rdata, 64'h0000_0000_8000_0001);

    // Directed transactions.
    run(1'b0, 3'd0, 1'b0, 32'h1003, 64'd0, 64'h80FF_FFFF, 0, 0, 0);
    run(1'b0, 3'd5, 1'b0, 32'h2002, 64'd0, 64'hBEEF_1234, 0, 0, 1);
    run(1'b0, 3'd1, 1'b1, 32'h2002, 64'hAAAA_5566, 64'hDEAD_BEEF, 0, 0, 0);
    run(1'b0, 3'd2, 1'b0, 32'h3001, 64'd0, 64'd0, 0, 0, 0);
    run(1'b0, 3'd3, 1'b0, 32'h3000, 64'd0, 64'd0, 0, 0, 2);
    run(1'b0, 3'd4, 1'b1, 32'h3000, 64'hFF, 64'd0, 0, 0, 0);
    run(1'b0, 3'd2, 1'b0, 32'h1000, 64'd0, 64'h1234_5678, 0, 6, 0);
    run(1'b0, 3'd2, 1'b0, 32'h1000, 64'd0, 64'h1234_5678, 3, 0, 0);
    run(1'b1, 3'd6, 1'b0, 32'h4004, 64'd0, 64'h8000_0001_1234_5678, 0, 0, 0);
    run(1'b1, 3'd3, 1'b1, 32'h4000, 64'h0123_4567_89AB_CDEF, 64'd0, 1, 1, 0);
    run(1'b1, 3'd0, 1'b1, 32'h4007, 64'h5A, 64'd0, 2, 0, 1);
    reset_in_wait();

    // Randomized transactions.
    for (int n = 0; n < 250; n++) begin
      logic [2:0]  r_op;
      logic [31:0] r_addr;
      r_op   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~32'((1 << r_op[1:0]) - 1);
      run(1'($urandom_range(0, 1)), r_op, ($urandom_range(0, 2) == 0), r_addr,
          {$urandom, $urandom}, {$urandom, $urandom},
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
